// File: rtl/param_reg_file_sb_if.sv
// Register-file bus: writeback, two read ports, reserve request and
// scoreboard status.
//   master : datapath/control side (drives addresses, write and reserve)
//   slave  : register file (returns read data, busy flags, status)
interface param_reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  we;
  logic [ADDR_W-1:0]     waddr;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic [ADDR_W-1:0]     raddr1;
  logic [ADDR_W-1:0]     raddr2;
  logic [DATA_W-1:0]     rdata1;
  logic [DATA_W-1:0]     rdata2;
  logic                  rsv;
  logic [ADDR_W-1:0]     rsv_addr;
  logic                  busy1;
  logic                  busy2;
  logic [ADDR_W:0]       busy_cnt;
  logic                  rsv_err;

  modport master (
    output we, waddr, wdata, wstrb, raddr1, raddr2, rsv, rsv_addr,
    input  rdata1, rdata2, busy1, busy2, busy_cnt, rsv_err
  );

  modport slave (
    input  we, waddr, wdata, wstrb, raddr1, raddr2, rsv, rsv_addr,
    output rdata1, rdata2, busy1, busy2, busy_cnt, rsv_err
  );
endinterface

// File: rtl/param_reg_file_sb.sv
// Parametrised register file with byte-strobed writes, optional same-cycle
// write-to-read bypass and a per-register busy scoreboard.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset (clears regs, busy bits, status)
//   bus    : param_reg_file_sb_if.slave -- write port (we/waddr/wdata/wstrb),
//            two combinational read ports (raddrN -> rdataN, busyN),
//            reserve request (rsv/rsv_addr), busy_cnt and rsv_err (registered)
module param_reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  param_reg_file_sb_if.slave   bus
);
  localparam int NUM_REGS = 2**ADDR_W;
  localparam int NB       = DATA_W/8;
  localparam int CNT_W    = ADDR_W+1;
  localparam int PORTS    = 2;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy;
  logic [CNT_W-1:0]                busy_cnt_q;
  logic                            rsv_err_q;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0] old_v,
    input logic [DATA_W-1:0] new_v,
    input logic [NB-1:0]     strb
  );
    logic [DATA_W-1:0] r;
    r = old_v;
    for (int i = 0; i < NB; i++)
      if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Requests that actually touch state (the zero register swallows both).
  logic              wr_ok, rsv_ok, same_addr;
  logic              busy_set, busy_clr;
  logic [DATA_W-1:0] wr_merged;

  assign wr_ok     = bus.we  && !is_zero(bus.waddr);
  assign rsv_ok    = bus.rsv && !is_zero(bus.rsv_addr);
  assign same_addr = (bus.waddr == bus.rsv_addr);
  assign wr_merged = merge(regs[bus.waddr], bus.wdata, bus.wstrb);

  // Real 0->1 / 1->0 transitions only. A reserve+write to the same busy
  // register keeps it busy (new producer), so it is neither set nor clear.
  assign busy_set = rsv_ok && !busy[bus.rsv_addr];
  assign busy_clr = wr_ok && busy[bus.waddr] && !(rsv_ok && same_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      regs       <= '0;
      busy       <= '0;
      busy_cnt_q <= '0;
      rsv_err_q  <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[bus.waddr] <= wr_merged;
        busy[bus.waddr] <= 1'b0;
      end
      // Placed after the clear so a same-address reserve wins.
      if (rsv_ok) busy[bus.rsv_addr] <= 1'b1;

      rsv_err_q <= rsv_ok && busy[bus.rsv_addr] && !(wr_ok && same_addr);

      if (busy_set && !busy_clr)      busy_cnt_q <= busy_cnt_q + CNT_W'(1);
      else if (busy_clr && !busy_set) busy_cnt_q <= busy_cnt_q - CNT_W'(1);
    end
  end

  // Read ports
  logic [PORTS-1:0][ADDR_W-1:0] raddr;
  logic [PORTS-1:0][DATA_W-1:0] rdata;
  logic [PORTS-1:0]             rbusy;

  assign raddr = {bus.raddr2, bus.raddr1};

  for (genvar p = 0; p < PORTS; p++) begin : g_rd
    logic hit_wr, hit_rsv;
    assign hit_wr  = (BYPASS != 0) && wr_ok && (bus.waddr == raddr[p]);
    assign hit_rsv = rsv_ok && (bus.rsv_addr == raddr[p]);

    always_comb begin
      rdata[p] = regs[raddr[p]];
      rbusy[p] = busy[raddr[p]];
      if (is_zero(raddr[p])) begin
        rdata[p] = '0;
        rbusy[p] = 1'b0;
      end else if (hit_wr) begin
        rdata[p] = wr_merged;
        // A pending writeback landing now is no longer a hazard, unless a
        // new reservation for the same register arrives in the same cycle.
        if (!hit_rsv) rbusy[p] = 1'b0;
      end
    end
  end

  assign bus.rdata1   = rdata[0];
  assign bus.rdata2   = rdata[1];
  assign bus.busy1    = rbusy[0];
  assign bus.busy2    = rbusy[1];
  assign bus.busy_cnt = busy_cnt_q;
  assign bus.rsv_err  = rsv_err_q;
endmodule

// File: tb/tb_param_reg_file_sb.sv
module tb_param_reg_file_sb;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus, fanned out to a bypass and a non-bypass build.
  logic        we, rsv;
  logic [4:0]  waddr, raddr1, raddr2, rsv_addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  param_reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) i1 ();
  param_reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) i0 ();

  assign i1.we = we;  assign i1.waddr = waddr;  assign i1.wdata = wdata;
  assign i1.wstrb = wstrb;  assign i1.raddr1 = raddr1;  assign i1.raddr2 = raddr2;
  assign i1.rsv = rsv;  assign i1.rsv_addr = rsv_addr;
  assign i0.we = we;  assign i0.waddr = waddr;  assign i0.wdata = wdata;
  assign i0.wstrb = wstrb;  assign i0.raddr1 = raddr1;  assign i0.raddr2 = raddr2;
  assign i0.rsv = rsv;  assign i0.rsv_addr = rsv_addr;

  param_reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1))
    dut (.clk(clk), .reset(reset), .bus(i1));
  param_reg_file_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0))
    dut_nb (.clk(clk), .reset(reset), .bus(i0));

  // Reference model: architectural register contents and set of busy regs.
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  bit          m_err;
  int          ncmp = 0, nerr = 0;

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we && waddr == a) return bmerge(m_regs[a], wdata, wstrb);
    return m_regs[a];
  endfunction

  function automatic logic exp_bz(input logic [4:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && we && waddr == a && !(rsv && rsv_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [5:0] exp_cnt();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
    return 6'(n);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("b1_rdata1", i1.rdata1, exp_rd(raddr1, 1));
    chk("b1_rdata2", i1.rdata2, exp_rd(raddr2, 1));
    chk("b1_busy1", {31'b0, i1.busy1}, {31'b0, exp_bz(raddr1, 1)});
    chk("b1_busy2", {31'b0, i1.busy2}, {31'b0, exp_bz(raddr2, 1)});
    chk("b1_busy_cnt", {26'b0, i1.busy_cnt}, {26'b0, exp_cnt()});
    chk("b1_rsv_err", {31'b0, i1.rsv_err}, {31'b0, m_err});
    chk("b0_rdata1", i0.rdata1, exp_rd(raddr1, 0));
    chk("b0_rdata2", i0.rdata2, exp_rd(raddr2, 0));
    chk("b0_busy1", {31'b0, i0.busy1}, {31'b0, exp_bz(raddr1, 0)});
    chk("b0_busy2", {31'b0, i0.busy2}, {31'b0, exp_bz(raddr2, 0)});
    chk("b0_busy_cnt", {26'b0, i0.busy_cnt}, {26'b0, exp_cnt()});
    chk("b0_rsv_err", {31'b0, i0.rsv_err}, {31'b0, m_err});
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    bit e;
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
      m_err = 0;
    end else begin
      e = rsv && rsv_addr != 0 && m_busy[rsv_addr] && !(we && waddr == rsv_addr);
      if (we && waddr != 0) begin
        m_regs[waddr] = bmerge(m_regs[waddr], wdata, wstrb);
        m_busy[waddr] = 0;
      end
      if (rsv && rsv_addr != 0) m_busy[rsv_addr] = 1;
      m_err = e;
    end
  endtask

  // Inputs are set just after a falling edge; settle, check, clock, return
  // at the next falling edge.
  task automatic cyc();
    #1;
    chk_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    we = 0; rsv = 0; wstrb = 4'h0; wdata = '0; waddr = '0; rsv_addr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1; idle(); raddr1 = 0; raddr2 = 0;
    for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 0; end
    m_err = 0;
    @(posedge clk); @(negedge clk);
    cyc();                      // outputs defined after the first reset edge
    reset = 0;
    raddr1 = 5; raddr2 = 5;
    cyc();
    chk("rst_r5", i1.rdata1, 32'h0);

    // 1: full write with bypass
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; wstrb = 4'hF;
    #1 chk("t1_bypass", i1.rdata1, 32'hDEADBEEF);
    chk("t1_nobypass_old", i0.rdata1, 32'h0);
    cyc(); idle();
    #1 chk("t1_next", i1.rdata1, 32'hDEADBEEF);
    chk("t1_next_nb", i0.rdata1, 32'hDEADBEEF);
    cyc();

    // 2: strobed write, zero-register write and reserve
    we = 1; waddr = 5; wdata = 32'h11223344; wstrb = 4'b0101;
    cyc(); idle();
    #1 chk("t2_strobe", i1.rdata1, 32'hDE22BE44);
    we = 1; waddr = 0; wdata = 32'hFFFFFFFF; wstrb = 4'hF; raddr2 = 0;
    #1 chk("t2_r0_bypass", i1.rdata2, 32'h0);
    cyc(); idle();
    rsv = 1; rsv_addr = 0;
    cyc(); idle();
    raddr1 = 0;
    #1 chk("t2_r0_busy", {31'b0, i1.busy1}, 32'h0);
    chk("t2_cnt", {26'b0, i1.busy_cnt}, 32'h0);
    chk("t2_r0_err", {31'b0, i1.rsv_err}, 32'h0);
    cyc();

    // 3: reserve then writeback; bypass build masks busy, the other does not
    rsv = 1; rsv_addr = 7; raddr1 = 7;
    cyc(); idle();
    #1 chk("t3_busy", {31'b0, i1.busy1}, 32'h1);
    chk("t3_cnt", {26'b0, i1.busy_cnt}, 32'h1);
    we = 1; waddr = 7; wdata = 32'h5; wstrb = 4'hF;
    #1 chk("t3_busy_masked", {31'b0, i1.busy1}, 32'h0);
    chk("t3_busy_nb", {31'b0, i0.busy1}, 32'h1);
    cyc(); idle();
    #1 chk("t3_cnt_after", {26'b0, i1.busy_cnt}, 32'h0);
    cyc();

    // 4: reserve and write same reg same cycle; then a double reserve
    rsv = 1; rsv_addr = 9; we = 1; waddr = 9; wdata = 32'h99; wstrb = 4'hF; raddr2 = 9;
    cyc(); idle();
    #1 chk("t4_busy", {31'b0, i1.busy2}, 32'h1);
    chk("t4_cnt", {26'b0, i1.busy_cnt}, 32'h1);
    rsv = 1; rsv_addr = 9;
    cyc(); idle();
    #1 chk("t4_err", {31'b0, i1.rsv_err}, 32'h1);
    chk("t4_cnt2", {26'b0, i1.busy_cnt}, 32'h1);
    cyc();
    chk("t4_err_clear", {31'b0, i1.rsv_err}, 32'h0);

    // 5: fill the scoreboard, then reset during a write
    for (int r = 1; r < 32; r++) begin
      rsv = 1; rsv_addr = 5'(r);
      cyc();
    end
    idle();
    #1 chk("t5_full", {26'b0, i1.busy_cnt}, 32'd31);
    rsv = 1; rsv_addr = 12;
    cyc(); idle();
    #1 chk("t5_nowrap", {26'b0, i1.busy_cnt}, 32'd31);
    reset = 1; we = 1; waddr = 3; wdata = 32'hCAFEF00D; wstrb = 4'hF; rsv = 1; rsv_addr = 4;
    cyc(); reset = 0; idle(); raddr1 = 3;
    #1 chk("t5_r3", i1.rdata1, 32'h0);
    chk("t5_cnt", {26'b0, i1.busy_cnt}, 32'h0);
    chk("t5_err", {31'b0, i1.rsv_err}, 32'h0);
    cyc();

    // 6: non-bypass build sees new data one cycle later
    we = 1; waddr = 4; wdata = 32'hA5; wstrb = 4'hF; raddr1 = 4;
    #1 chk("t6_old", i0.rdata1, 32'h0);
    cyc(); idle();
    #1 chk("t6_new", i0.rdata1, 32'hA5);
    cyc();

    // Randomized traffic on a narrow address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 59) == 0);
      we       = 1'($urandom);
      waddr    = 5'($urandom_range(0, 7));
      wdata    = $urandom;
      wstrb    = 4'($urandom);
      rsv      = 1'($urandom);
      rsv_addr = 5'($urandom_range(0, 7));
      raddr1   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      raddr2   = 5'($urandom_range(0, 7));
      cyc();
    end
    reset = 0; idle();
    for (int r = 1; r < 32; r++) begin
      rsv = 1'($urandom); rsv_addr = 5'(r); raddr1 = 5'(r); raddr2 = 5'(32 - r);
      cyc();
    end
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
